mem_stage: RTL
==============

Name: mem_stage

Overview:
- Memory-access stage that sits directly downstream of the EX stage and consumes the EX/MEM values: the ALU result, the store data and the control bits.
- Runs loads and stores against a data-memory port using a request/ready handshake.
- Performs byte-lane alignment, and sign- or zero-extension of load data.
- Stalls the upstream pipeline while an access is outstanding, then drives a registered MEM/WB output bundle.

Parameters:
- TIMEOUT_CYCLES, default 255: BUSY cycles without dmem_ready before the access is aborted with an exception. Legal range 1..255.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous active-low reset
- in_valid  in  1  an instruction is present in EX/MEM
- alu_result  in  32  effective address, or the ALU value for non-memory ops
- rs2_data  in  32  store data
- funct3  in  3  access size and signedness
- mem_read  in  1  load
- mem_write  in  1  store
- rd  in  5  destination register
- reg_write  in  1  instruction writes rd
- mem_stall  out  1  hold the EX/MEM register and everything upstream (combinational)
- dmem_req  out  1  memory request
- dmem_we  out  1  write enable
- dmem_addr  out  32  word-aligned address
- dmem_wdata  out  32  lane-replicated store data
- dmem_wstrb  out  4  byte strobes
- dmem_ready  in  1  access complete; dmem_rdata valid this cycle
- dmem_rdata  in  32  read word
- wb_valid  out  1  MEM/WB valid
- wb_data  out  32  load result or passed-through alu_result
- wb_rd  out  5  destination register
- wb_reg_write  out  1  register write enable
- wb_exc  out  1  misaligned, illegal or timed-out access

Behaviour:
- Reset: all wb_* outputs are 0; state goes to IDLE; the timeout counter clears. dmem_req, dmem_we and dmem_wstrb are 0 and mem_stall is 0 whenever the state is IDLE.
- Reset mid-access (rst_n low while BUSY): dmem_req drops in the same cycle; the outstanding access is abandoned and no wb_valid is produced for it.
- States: IDLE and BUSY.
- Decode rules:
  - memop = in_valid & (mem_read | mem_write).
  - Legal load funct3: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU. Legal store funct3: 000 SB, 001 SH, 010 SW.
  - Alignment: halfword requires addr[0]=0; word requires addr[1:0]=00.
  - bad = mem_read & mem_write, or an illegal funct3, or misaligned.
- IDLE, non-memop with in_valid: next edge loads wb_valid=1, wb_data=alu_result, wb_rd=rd, wb_reg_write=reg_write, wb_exc=0. mem_stall=0.
- IDLE, memop with bad: no request is issued and mem_stall=0. Next edge loads wb_valid=1, wb_exc=1, wb_reg_write=0 and wb_data=alu_result.
- IDLE, memop legal: mem_stall=1. Capture address, data, funct3, rd, reg_write and direction; go to BUSY and clear the counter.
- BUSY:
  - Drives dmem_req=1 and dmem_addr={addr[31:2],2'b00}. For stores it drives dmem_we=1 and the strobes/data below.
  - mem_stall = !dmem_ready & !timeout.
- BUSY, dmem_ready=1: return to IDLE. Next edge loads wb_valid=1, wb_exc=0, wb_rd and wb_reg_write from the captured values.
  - Load result wb_data: the byte/half is selected by addr[1:0], then extended.
    - LB/LH: sign-extend.
    - LBU/LHU: zero-extend.
    - LW: the whole word.
  - Store result: wb_data = captured address.
- Timeout: the counter increments on each BUSY cycle without dmem_ready. When the count reaches TIMEOUT_CYCLES:
  - drop the request;
  - go to IDLE;
  - next edge loads wb_valid=1, wb_exc=1, wb_reg_write=0.
  - If dmem_ready is high in that same cycle, ready wins and there is no exception.
- Store lanes:
  - SB: wstrb = 0001<<addr[1:0], wdata = {4{rs2[7:0]}}.
  - SH: wstrb = 0011<<addr[1:0], wdata = {2{rs2[15:0]}}.
  - SW: wstrb = 1111, wdata = rs2.
- Any cycle without an instruction completing, including stall cycles and cycles with in_valid=0: next edge loads wb_valid=0 and wb_reg_write=0 (a bubble). wb_data and wb_rd may hold their previous values.
- Latency:
  - Non-memop: 1 cycle.
  - Memory op: 1 IDLE cycle, then k≥1 BUSY cycles, then wb on the following edge.
  - Upstream advances in the cycle where mem_stall=0.
- dmem_rdata is sampled only when state=BUSY, the op is a load and dmem_ready=1.

Test Plan:
- ADD passthrough, alu_result=0x0000_1234, rd=5, reg_write=1 -> wb_valid=1, wb_data=0x1234, wb_rd=5 one edge later; mem_stall never 1.
- LB at addr 0x103, ready after 2 BUSY cycles, rdata=0x80FF_1122 -> dmem_addr=0x100; mem_stall high for 2 cycles; wb_data=0xFFFF_FF80. Repeat as LBU -> wb_data=0x0000_0080.
- SH at addr 0x202, rs2=0xDEAD_BEEF -> dmem_we=1, wstrb=1100, wdata=0xBEEF_BEEF; wb_reg_write=0, wb_exc=0.
- LW at addr 0x101 -> dmem_req stays 0; wb_exc=1 and wb_reg_write=0 next edge; no stall. Repeat with funct3=011 load and mem_read=mem_write=1 -> same exception response.
- LW with dmem_ready held low, TIMEOUT_CYCLES=4 -> dmem_req high 4 cycles then low; wb_exc=1. Repeat with ready arriving on the 4th cycle -> normal completion, wb_exc=0.
- rst_n low on the second BUSY cycle of an SW -> dmem_req=0 that cycle; all wb_* outputs 0 after the edge; the next instruction after reset completes normally.

Source files
------------

// File: rtl/mem_stage.sv
// mem_stage: memory-access pipeline stage between EX/MEM and MEM/WB.
//   Decodes load/store control bits, rejects misaligned or illegal accesses,
//   runs one access at a time against a req/ready data-memory port, aligns
//   store lanes and extends load data, and registers the MEM/WB bundle.
// Ports:
//   clk, rst_n             clock, synchronous active-low reset
//   in_valid .. reg_write  EX/MEM inputs (address/ALU value, store data, ctrl)
//   mem_stall              hold EX/MEM and upstream (combinational)
//   dmem_*                 data-memory request/response port
//   wb_*                   registered MEM/WB outputs
module mem_stage #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  input  logic [31:0] alu_result,
  input  logic [31:0] rs2_data,
  input  logic [2:0]  funct3,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [4:0]  rd,
  input  logic        reg_write,
  output logic        mem_stall,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  output logic [3:0]  dmem_wstrb,
  input  logic        dmem_ready,
  input  logic [31:0] dmem_rdata,
  output logic        wb_valid,
  output logic [31:0] wb_data,
  output logic [4:0]  wb_rd,
  output logic        wb_reg_write,
  output logic        wb_exc
);
  typedef enum logic {IDLE, BUSY} state_t;

  // Timeout fires in the BUSY cycle whose count is one short of the limit,
  // so the request is visible for exactly TIMEOUT_CYCLES cycles.
  localparam logic [7:0] LP_LAST = 8'(TIMEOUT_CYCLES - 1);

  state_t      r_state;
  logic [7:0]  r_cnt;
  logic [31:0] r_addr, r_wdata;
  logic [2:0]  r_f3;
  logic [4:0]  r_rd;
  logic        r_regw, r_store;
  logic        r_wb_valid, r_wb_regw, r_wb_exc;
  logic [31:0] r_wb_data;
  logic [4:0]  r_wb_rd;

  logic        w_memop, w_f3_ok, w_misal, w_bad, w_busy, w_timeout;
  logic [31:0] w_sh, w_load, w_wd;
  logic [3:0]  w_strb;

  assign w_memop = in_valid & (mem_read | mem_write);

  always_comb begin
    w_f3_ok = 1'b0;
    case (funct3)
      3'b000, 3'b001, 3'b010: w_f3_ok = 1'b1;
      3'b100, 3'b101:         w_f3_ok = ~mem_write;
      default:                w_f3_ok = 1'b0;
    endcase
    w_misal = 1'b0;
    case (funct3[1:0])
      2'b01:   w_misal = alu_result[0];
      2'b10:   w_misal = |alu_result[1:0];
      default: w_misal = 1'b0;
    endcase
  end

  assign w_bad = (mem_read & mem_write) | ~w_f3_ok | w_misal;

  // Reset drops the request combinationally so an abandoned access never
  // sees another cycle of dmem_req.
  assign w_busy    = (r_state == BUSY) & rst_n;
  assign w_timeout = (r_state == BUSY) & (r_cnt == LP_LAST);

  always_comb begin
    w_sh = dmem_rdata >> {r_addr[1:0], 3'b000};
    case (r_f3)
      3'b000:  w_load = {{24{w_sh[7]}}, w_sh[7:0]};
      3'b001:  w_load = {{16{w_sh[15]}}, w_sh[15:0]};
      3'b100:  w_load = {24'd0, w_sh[7:0]};
      3'b101:  w_load = {16'd0, w_sh[15:0]};
      default: w_load = dmem_rdata;
    endcase
    case (r_f3[1:0])
      2'b00: begin
        w_strb = 4'b0001 << r_addr[1:0];
        w_wd   = {4{r_wdata[7:0]}};
      end
      2'b01: begin
        w_strb = 4'b0011 << r_addr[1:0];
        w_wd   = {2{r_wdata[15:0]}};
      end
      default: begin
        w_strb = 4'b1111;
        w_wd   = r_wdata;
      end
    endcase
  end

  assign dmem_req   = w_busy;
  assign dmem_we    = w_busy & r_store;
  assign dmem_wstrb = (w_busy & r_store) ? w_strb : 4'b0000;
  assign dmem_wdata = w_wd;
  assign dmem_addr  = {r_addr[31:2], 2'b00};

  always_comb begin
    mem_stall = 1'b0;
    if (r_state == IDLE) mem_stall = w_memop & ~w_bad;
    else                 mem_stall = ~dmem_ready & ~w_timeout;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_cnt      <= '0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_f3       <= '0;
      r_rd       <= '0;
      r_regw     <= 1'b0;
      r_store    <= 1'b0;
      r_wb_valid <= 1'b0;
      r_wb_regw  <= 1'b0;
      r_wb_exc   <= 1'b0;
      r_wb_data  <= '0;
      r_wb_rd    <= '0;
    end else begin
      // Bubble unless an instruction completes this cycle.
      r_wb_valid <= 1'b0;
      r_wb_regw  <= 1'b0;
      r_wb_exc   <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_memop && w_bad) begin
            r_wb_valid <= 1'b1;
            r_wb_exc   <= 1'b1;
            r_wb_data  <= alu_result;
            r_wb_rd    <= rd;
          end else if (w_memop) begin
            r_state <= BUSY;
            r_cnt   <= '0;
            r_addr  <= alu_result;
            r_wdata <= rs2_data;
            r_f3    <= funct3;
            r_rd    <= rd;
            r_regw  <= reg_write;
            r_store <= mem_write;
          end else if (in_valid) begin
            r_wb_valid <= 1'b1;
            r_wb_regw  <= reg_write;
            r_wb_data  <= alu_result;
            r_wb_rd    <= rd;
          end
        end
        BUSY: begin
          if (dmem_ready) begin
            r_state    <= IDLE;
            r_wb_valid <= 1'b1;
            r_wb_regw  <= r_regw;
            r_wb_rd    <= r_rd;
            r_wb_data  <= r_store ? r_addr : w_load;
          end else if (w_timeout) begin
            r_state    <= IDLE;
            r_wb_valid <= 1'b1;
            r_wb_exc   <= 1'b1;
            r_wb_rd    <= r_rd;
            r_wb_data  <= r_addr;
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign wb_valid     = r_wb_valid;
  assign wb_data      = r_wb_data;
  assign wb_rd        = r_wb_rd;
  assign wb_reg_write = r_wb_regw;
  assign wb_exc       = r_wb_exc;
endmodule
